// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Bits needed to hold 0..value-1; never less than 1 so counters stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value == 0) ? 0 : value - 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((v >> i) != 0) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw line one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Stage registers; reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity/framing/overrun flags and a valid/ready output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 input_stream,
  output logic [DATA_BITS-1:0] output_stream,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = clog2(CLKS_PER_BIT);
  localparam int unsigned BW           = clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP   = BW'(STOP_BITS - 1);
  localparam logic          ODD_MODE    = (PARITY == PAR_ODD);
  localparam logic          HAS_PARITY  = (PARITY != PAR_NONE);

  logic rx;

  state_e                 state_q, state_d;
  logic [CW-1:0]          baud_cnt_q, baud_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_pend_q, par_pend_d;
  logic                   frm_pend_q, frm_pend_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic tick;
  logic deliver;
  logic accept;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (input_stream),
    .q     (rx)
  );

  assign tick    = (baud_cnt_q == '0);
  assign deliver = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);
  assign accept  = out_valid_q && out_ready;

  // All state, counters and output holding registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_pend_q   <= 1'b0;
      frm_pend_q   <= 1'b0;
      armed_q      <= 1'b1;
      data_q       <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_pend_q   <= par_pend_d;
      frm_pend_q   <= frm_pend_d;
      armed_q      <= armed_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Frame sequencing: leave STOP on its last mid-bit sample so back-to-back frames are caught.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (armed_q && !rx) state_d = ST_START;
      ST_START: if (tick) state_d = rx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && (bit_cnt_q == LAST_DATA)) state_d = HAS_PARITY ? ST_PAR : ST_STOP;
      ST_PAR:   if (tick) state_d = ST_STOP;
      ST_STOP:  if (tick && (bit_cnt_q == LAST_STOP)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Baud/bit counters, data shifter, pending error flags and break re-arm.
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    armed_d    = armed_q;

    if (state_q == ST_IDLE)  baud_cnt_d = HALF_RELOAD;
    else if (tick)           baud_cnt_d = BAUD_RELOAD;
    else                     baud_cnt_d = baud_cnt_q - CW'(1);

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = '0;
        par_pend_d = 1'b0;
        frm_pend_d = 1'b0;
        if (rx) armed_d = 1'b1;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {rx, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = (bit_cnt_q == LAST_DATA) ? '0 : bit_cnt_q + BW'(1);
        end
      end
      ST_PAR: begin
        if (tick) par_pend_d = (^shift_q) ^ rx ^ ODD_MODE;
      end
      ST_STOP: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (!rx) begin
            frm_pend_d = 1'b1;
            armed_d    = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Output word and flags: load on delivery (the stop sample itself folds into frame_err), clear on acceptance.
  always_comb begin
    data_d       = data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    if (deliver) begin
      data_d       = shift_q;
      out_valid_d  = 1'b1;
      parity_err_d = HAS_PARITY && par_pend_q;
      frame_err_d  = frm_pend_q | ~rx;
      overrun_d    = out_valid_q && !out_ready;
    end else if (accept) begin
      out_valid_d  = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  assign output_stream = data_q;
  assign out_valid     = out_valid_q;
  assign parity_err    = parity_err_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: two receiver configurations (8E1 and 7O2) driven with directed and random frames.
module tb_uart_rx_param;

  localparam int unsigned CLK_HZ    = 1600;
  localparam int unsigned BAUD_RATE = 100;
  localparam int unsigned CPB       = CLK_HZ / BAUD_RATE;
  localparam int unsigned HALF      = CPB / 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       line_a = 1'b1, ready_a = 1'b1;
  logic [7:0] data_a;
  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;

  logic       line_b = 1'b1, ready_b = 1'b1;
  logic [6:0] data_b;
  logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

  always #5 clock = ~clock;

  uart_rx_param #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_RATE), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
    .clock(clock), .reset(reset), .input_stream(line_a), .output_stream(data_a),
    .out_valid(valid_a), .out_ready(ready_a), .parity_err(perr_a),
    .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_param #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_RATE), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(3)) dut_b (
    .clock(clock), .reset(reset), .input_stream(line_b), .output_stream(data_b),
    .out_valid(valid_b), .out_ready(ready_b), .parity_err(perr_b),
    .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Frame format of each instance: sel=0 -> 8 data, even parity, 1 stop; sel=1 -> 7 data, odd parity, 2 stops.
  function automatic int unsigned nbits(input bit sel);
    return sel ? 7 : 8;
  endfunction

  function automatic logic good_pbit(input bit sel, input logic [8:0] d);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < nbits(sel); i++) ones += int'(d[i]);
    // Even: make total ones even; odd: make total ones odd.
    return sel ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
  endfunction

  task automatic push_exp(input bit sel, input logic [8:0] d, input logic pbit,
                          input logic [1:0] stops, input logic ovr);
    exp_t e;
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < nbits(sel); i++) ones += int'(d[i]);
    ones += int'(pbit);
    e.data = sel ? {2'b00, d[6:0]} : {1'b0, d[7:0]};
    e.perr = sel ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    e.ferr = sel ? !(stops[0] && stops[1]) : !stops[0];
    e.ovr  = ovr;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Entered and left at posedge+1.
  task automatic drive(input bit sel, input logic b, input int unsigned nclk);
    if (sel) line_b = b;
    else     line_a = b;
    if (nclk != 0) begin
      repeat (nclk) @(posedge clock);
      #1;
    end
  endtask

  task automatic frame(input bit sel, input logic [8:0] d, input logic pbit, input logic [1:0] stops,
                       input bit push, input logic gap_level, input int unsigned gap_bits);
    if (push) push_exp(sel, d, pbit, stops, 1'b0);
    drive(sel, 1'b0, CPB);
    for (int unsigned i = 0; i < nbits(sel); i++) drive(sel, d[i], CPB);
    drive(sel, pbit, CPB);
    for (int unsigned s = 0; s < (sel ? 2 : 1); s++) drive(sel, stops[s], CPB);
    drive(sel, gap_level, gap_bits * CPB);
  endtask

  task automatic good_frame(input bit sel, input logic [8:0] d, input int unsigned gap_bits);
    frame(sel, d, good_pbit(sel, d), 2'b11, 1'b1, 1'b1, gap_bits);
  endtask

  // Hold a word unaccepted, then reset part-way into data bit 4 of a new frame.
  task automatic reset_mid_frame(input bit sel, input logic [8:0] d);
    if (sel) ready_b = 1'b0;
    else     ready_a = 1'b0;
    frame(sel, 9'h077, good_pbit(sel, 9'h077), 2'b11, 1'b0, 1'b1, 1);
    drive(sel, 1'b0, CPB);
    for (int unsigned i = 0; i < 4; i++) drive(sel, d[i], CPB);
    drive(sel, d[4], CPB / 2);
    drive(sel, 1'b1, 0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    if (sel) chk("b_reset_mid_outputs", 32'({data_b, valid_b, perr_b, ferr_b, ovr_b, busy_b}), 32'h0);
    else     chk("a_reset_mid_outputs", 32'({data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a}), 32'h0);
    @(posedge clock);
    #1;
    if (sel) ready_b = 1'b1;
    else     ready_a = 1'b1;
    drive(sel, 1'b1, 2 * CPB);
  endtask

  // Monitor for instance A: every accepted word is compared with the oldest expectation.
  always @(negedge clock) begin
    if (!reset && valid_a && ready_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_word: actual data=%0h required no word", data_a);
      end else begin
        ea = q_a.pop_front();
        chk("a_data", 32'(data_a), 32'(ea.data));
        chk("a_parity_err", 32'(perr_a), 32'(ea.perr));
        chk("a_frame_err", 32'(ferr_a), 32'(ea.ferr));
        chk("a_overrun", 32'(ovr_a), 32'(ea.ovr));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clock) begin
    if (!reset && valid_b && ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_word: actual data=%0h required no word", data_b);
      end else begin
        eb = q_b.pop_front();
        chk("b_data", 32'(data_b), 32'(eb.data));
        chk("b_parity_err", 32'(perr_b), 32'(eb.perr));
        chk("b_frame_err", 32'(ferr_b), 32'(eb.ferr));
        chk("b_overrun", 32'(ovr_b), 32'(eb.ovr));
      end
    end
  end

  initial begin
    logic [8:0]  d;
    logic        bad_p, bad_s, seen_busy;
    logic [1:0]  st;
    int unsigned gap;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("a_reset_outputs", 32'({data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a}), 32'h0);
    chk("b_reset_outputs", 32'({data_b, valid_b, perr_b, ferr_b, ovr_b, busy_b}), 32'h0);
    @(posedge clock);
    #1;
    drive(0, 1'b1, 2 * CPB);

    // Instance A: correct and wrong parity on 0x93.
    good_frame(0, 9'h093, 2);
    frame(0, 9'h093, 1'b1, 2'b11, 1'b1, 1'b1, 2);

    // Start glitch shorter than half a bit.
    seen_busy = 1'b0;
    for (int unsigned i = 0; i < 3 + HALF + 2 + 4; i++) begin
      line_a = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clock);
      if (busy_a) seen_busy = 1'b1;
      @(posedge clock);
      #1;
    end
    chk("a_glitch_busy_seen", 32'(seen_busy), 32'h1);
    chk("a_glitch_busy_cleared", 32'(busy_a), 32'h0);
    drive(0, 1'b1, CPB);

    // Framing error followed by a 5-bit break; only one word, then recovery once the line is high.
    frame(0, 9'h041, good_pbit(0, 9'h041), 2'b10, 1'b1, 1'b0, 5);
    chk("a_break_single_word", 32'(q_a.size()), 32'h0);
    drive(0, 1'b1, CPB);
    good_frame(0, 9'h05A, 1);

    // Random frames, occasionally with bad parity or stop bit.
    for (int k = 0; k < 24; k++) begin
      d     = 9'($urandom_range(0, 255));
      bad_p = ($urandom_range(0, 3) == 0);
      bad_s = ($urandom_range(0, 4) == 0);
      st    = bad_s ? 2'b10 : 2'b11;
      gap   = bad_s ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
      frame(0, d, good_pbit(0, d) ^ bad_p, st, 1'b1, 1'b1, gap);
    end

    // Overrun: back-to-back 0x55 then 0xAA with nobody accepting.
    ready_a = 1'b0;
    frame(0, 9'h055, good_pbit(0, 9'h055), 2'b11, 1'b0, 1'b1, 0);
    frame(0, 9'h0AA, good_pbit(0, 9'h0AA), 2'b11, 1'b0, 1'b1, 1);
    @(negedge clock);
    chk("a_ovr_valid_held", 32'(valid_a), 32'h1);
    chk("a_ovr_data", 32'(data_a), 32'h0AA);
    chk("a_ovr_flag", 32'(ovr_a), 32'h1);
    @(posedge clock);
    #1;
    push_exp(0, 9'h0AA, good_pbit(0, 9'h0AA), 2'b11, 1'b1);
    ready_a = 1'b1;
    @(posedge clock);
    #1 ready_a = 1'b0;
    @(negedge clock);
    chk("a_accept_clears_valid", 32'(valid_a), 32'h0);
    chk("a_accept_clears_overrun", 32'(ovr_a), 32'h0);
    @(posedge clock);
    #1 ready_a = 1'b1;

    reset_mid_frame(0, 9'h0C3);
    good_frame(0, 9'h03C, 2);

    // Instance B (7 data, odd parity, 2 stops).
    good_frame(1, 9'h05A, 1);
    frame(1, 9'h05A, ~good_pbit(1, 9'h05A), 2'b11, 1'b1, 1'b1, 1);
    frame(1, 9'h05A, good_pbit(1, 9'h05A), 2'b01, 1'b1, 1'b1, 2);
    for (int k = 0; k < 8; k++) begin
      d     = 9'($urandom_range(0, 127));
      bad_p = ($urandom_range(0, 3) == 0);
      bad_s = ($urandom_range(0, 4) == 0);
      st    = bad_s ? 2'($urandom_range(0, 2)) : 2'b11;
      gap   = bad_s ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
      frame(1, d, good_pbit(1, d) ^ bad_p, st, 1'b1, 1'b1, gap);
    end
    reset_mid_frame(1, 9'h025);
    good_frame(1, 9'h05A, 2);

    drive(0, 1'b1, 4 * CPB);
    chk("a_queue_drained", 32'(q_a.size()), 32'h0);
    chk("b_queue_drained", 32'(q_b.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
